// File: rtl/spi_master_burst.sv
// Full-duplex SPI master with run-time mode/bit order, configurable word length and
// multi-word bursts that keep one slave select asserted between words.
module spi_master_burst #(
  parameter int WORD_LENGTH      = 8,
  parameter int CLK_PER_HALF_BIT = 4,
  parameter int NUM_SLAVES       = 4,
  localparam int SSW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_cpol,
  input  logic                   cfg_cpha,
  input  logic                   cfg_lsb_first,
  input  logic [SSW-1:0]         cfg_ss_sel,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [WORD_LENGTH-1:0] tx_data,
  input  logic                   tx_last,
  output logic                   rx_valid,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   busy,
  output logic                   sclk,
  output logic                   mosi,
  output logic [NUM_SLAVES-1:0]  ss_n,
  input  logic                   miso
);

  localparam int CNT_W  = $clog2(CLK_PER_HALF_BIT);
  localparam int EDGE_W = $clog2(2 * WORD_LENGTH + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  function automatic logic [WORD_LENGTH-1:0] bit_reverse(input logic [WORD_LENGTH-1:0] w);
    for (int i = 0; i < WORD_LENGTH; i++) begin
      bit_reverse[i] = w[WORD_LENGTH-1-i];
    end
  endfunction

  logic [2:0]             state_r;
  logic [2:0]             state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [EDGE_W-1:0]      edges_r;
  logic [WORD_LENGTH-1:0] tx_shift_r;
  logic [WORD_LENGTH-1:0] rx_shift_r;
  logic [WORD_LENGTH-1:0] rx_data_r;
  logic                   rx_valid_r;
  logic                   tx_ready_r;
  logic                   busy_r;
  logic                   sclk_r;
  logic                   mosi_r;
  logic [NUM_SLAVES-1:0]  ss_n_r;
  logic                   cpol_r;
  logic                   cpha_r;
  logic                   lsb_r;
  logic [SSW-1:0]         sel_r;
  logic                   last_r;

  logic                   accept_s;
  logic                   first_s;
  logic                   cnt_wrap_s;
  logic                   cpha_eff_s;
  logic                   lsb_eff_s;
  logic [SSW-1:0]         sel_nxt_s;
  logic [WORD_LENGTH-1:0] data_ord_s;
  logic                   lead_s;
  logic                   final_s;
  logic                   edge_s;
  logic                   sample_s;
  logic                   drive_s;
  logic                   ss_active_s;
  logic [NUM_SLAVES-1:0]  ss_n_nxt_s;

  // Next-state, edge scheduling and slave-select decode
  always_comb begin
    accept_s   = tx_valid & tx_ready_r;
    first_s    = (state_r == ST_IDLE);
    cnt_wrap_s = (cnt_r == CNT_W'(CLK_PER_HALF_BIT - 1));
    cpha_eff_s = first_s ? cfg_cpha : cpha_r;
    lsb_eff_s  = first_s ? cfg_lsb_first : lsb_r;
    sel_nxt_s  = (accept_s && first_s) ? cfg_ss_sel : sel_r;
    data_ord_s = lsb_eff_s ? bit_reverse(tx_data) : tx_data;
    // Edge numbering is odd for leading edges; edges_r counts down from an even total.
    lead_s     = ~edges_r[0];
    final_s    = (edges_r == EDGE_W'(1));
    edge_s     = ((state_r == ST_SETUP) && cnt_wrap_s) ||
                 ((state_r == ST_SHIFT) && (edges_r != EDGE_W'(0)) && cnt_wrap_s);
    sample_s   = lead_s ^ cpha_r;
    drive_s    = ~sample_s & ~final_s;

    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_SETUP;
        else          state_nxt_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (cnt_wrap_s) state_nxt_s = ST_SHIFT;
        else            state_nxt_s = ST_SETUP;
      end
      ST_SHIFT: begin
        if (edges_r == EDGE_W'(0)) state_nxt_s = last_r ? ST_HOLD : ST_WAIT;
        else                       state_nxt_s = ST_SHIFT;
      end
      ST_WAIT: begin
        if (accept_s) state_nxt_s = ST_SETUP;
        else          state_nxt_s = ST_WAIT;
      end
      ST_HOLD: begin
        if (cnt_wrap_s) state_nxt_s = ST_GAP;
        else            state_nxt_s = ST_HOLD;
      end
      ST_GAP: begin
        if (cnt_wrap_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    ss_active_s = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_SHIFT) ||
                  (state_nxt_s == ST_WAIT)  || (state_nxt_s == ST_HOLD);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      ss_n_nxt_s[i] = ~(ss_active_s && (sel_nxt_s == SSW'(i)));
    end
  end

  // Sequencer, shift registers and registered SPI/handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      edges_r    <= '0;
      tx_shift_r <= '0;
      rx_shift_r <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      tx_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      ss_n_r     <= '1;
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      lsb_r      <= 1'b0;
      sel_r      <= '0;
      last_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_WAIT);
      busy_r     <= (state_nxt_s != ST_IDLE);
      ss_n_r     <= ss_n_nxt_s;
      rx_valid_r <= 1'b0;

      if ((state_nxt_s != state_r) || cnt_wrap_s) cnt_r <= '0;
      else                                         cnt_r <= cnt_r + CNT_W'(1);

      if (state_r == ST_IDLE) sclk_r <= cfg_cpol;
      else if (edge_s)        sclk_r <= ~sclk_r;

      if (accept_s) begin
        last_r     <= tx_last;
        edges_r    <= EDGE_W'(2 * WORD_LENGTH);
        rx_shift_r <= '0;
        if (first_s) begin
          cpol_r <= cfg_cpol;
          cpha_r <= cfg_cpha;
          lsb_r  <= cfg_lsb_first;
          sel_r  <= cfg_ss_sel;
        end
        // CPHA=0 slaves sample on the first edge, so the first bit must already be out.
        if (!cpha_eff_s) begin
          mosi_r     <= data_ord_s[WORD_LENGTH-1];
          tx_shift_r <= data_ord_s << 1;
        end else begin
          tx_shift_r <= data_ord_s;
        end
      end else if (edge_s) begin
        edges_r <= edges_r - EDGE_W'(1);
        if (sample_s) begin
          if (lsb_r) rx_shift_r <= {miso, rx_shift_r[WORD_LENGTH-1:1]};
          else       rx_shift_r <= {rx_shift_r[WORD_LENGTH-2:0], miso};
        end
        if (drive_s) begin
          mosi_r     <= tx_shift_r[WORD_LENGTH-1];
          tx_shift_r <= tx_shift_r << 1;
        end
      end

      if ((state_r == ST_SHIFT) && (edges_r == EDGE_W'(0))) begin
        rx_valid_r <= 1'b1;
        rx_data_r  <= rx_shift_r;
      end
    end
  end

  assign tx_ready = tx_ready_r;
  assign rx_valid = rx_valid_r;
  assign rx_data  = rx_data_r;
  assign busy     = busy_r;
  assign sclk     = sclk_r;
  assign mosi     = mosi_r;
  assign ss_n     = ss_n_r;

endmodule

// File: tb/tb_spi_master_burst.sv
// Directed bench for spi_master_burst: expected received words go into a scoreboard
// queue when issued; a monitor pops and compares on every rx_valid pulse.
module tb_spi_master_burst;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic [1:0] cfg_ss_sel;
  logic       tx_valid, tx_ready, tx_last;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy, sclk, mosi, miso;
  logic [3:0] ss_n;

  logic       slave_en;
  logic       slave_miso = 1'b0;
  logic [7:0] slave_word = 8'h81;
  int         slave_idx = 0;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         rx_count = 0;
  int         rx_cyc = 0;
  int         ss_bad = 0;
  int         mosi_bad = 0;
  logic       ss_watch = 1'b0;
  logic [3:0] ss_exp = 4'hF;
  logic       mode_chk = 1'b0;
  logic       sclk_prev = 1'b0;
  logic       mosi_prev = 1'b0;
  logic [7:0] mosi_seq = 8'h00;
  logic [7:0] exp_q[$];
  int         edge_q[$];

  assign miso = slave_en ? slave_miso : mosi;

  spi_master_burst #(.WORD_LENGTH(8), .CLK_PER_HALF_BIT(4), .NUM_SLAVES(4)) dut (
    .clk(clk), .rst(rst), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .cfg_ss_sel(cfg_ss_sel),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave for the mode-3 LSB-first case: shifts the next bit of slave_word on each falling edge
  always @(negedge sclk) begin
    if (slave_en && !ss_n[0]) begin
      slave_miso <= slave_word[slave_idx];
      slave_idx  <= (slave_idx + 1) % 8;
    end
  end

  // Pin monitor and scoreboard, sampled on the inactive clock edge
  always @(negedge clk) begin
    if (sclk !== sclk_prev) begin
      edge_q.push_back(cyc);
      if (sclk) mosi_seq <= {mosi_seq[6:0], mosi};
    end
    if (mode_chk && (mosi !== mosi_prev) && !(sclk_prev && !sclk)) mosi_bad <= mosi_bad + 1;
    if (ss_watch && (ss_n !== ss_exp)) ss_bad <= ss_bad + 1;
    sclk_prev <= sclk;
    mosi_prev <= mosi;
    if (rx_valid === 1'b1) begin
      rx_count <= rx_count + 1;
      rx_cyc   <= cyc;
      if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hDEAD_BEEF);
      else                   check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_word(input logic [7:0] d, input logic l, output int t);
    int n = 0;
    tx_valid = 1'b1; tx_data = d; tx_last = l;
    while (tx_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", 32'(n < 500), 32'h1);
    t = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 1000), 32'h1);
    t = cyc;
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_count < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rx_timeout", 32'(n < 1000), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, ti, base, bad, n;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_ss_sel = 2'd0;
    slave_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'h0);
    check("rst_ss_n", 32'(ss_n), 32'hF);
    check("rst_tx_ready", 32'(tx_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(tx_ready), 32'h1);

    // Mode 0, MSB-first, loopback, single word
    @(negedge clk);
    edge_q.delete(); base = rx_count;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 1'b1, t);
    check("t1_ss_n", 32'(ss_n), 32'hE);
    wait_idle(ti);
    check("t1_edge_count", 32'(edge_q.size()), 32'd16);
    check("t1_first_edge", 32'((edge_q.size() > 0) ? edge_q[0] : -1), 32'(t + 5));
    check("t1_last_edge", 32'((edge_q.size() > 15) ? edge_q[15] : -1), 32'(t + 65));
    bad = 0;
    for (int i = 1; i < edge_q.size(); i++) if (edge_q[i] - edge_q[i-1] != 4) bad++;
    check("t1_edge_spacing", 32'(bad), 32'h0);
    check("t1_rx_cycle", 32'(rx_cyc), 32'(t + 66));
    check("t1_rx_pulses", 32'(rx_count - base), 32'd1);
    check("t1_idle_cycle", 32'(ti), 32'(t + 74));
    check("t1_ss_idle", 32'(ss_n), 32'hF);

    // Mode 3, LSB-first, slave returns 0x81
    slave_en = 1'b1; cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_lsb_first = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_sclk_idle", 32'(sclk), 32'h1);
    base = mosi_bad; mode_chk = 1'b1;
    exp_q.push_back(8'h81);
    send_word(8'h3C, 1'b1, t);
    wait_idle(ti);
    mode_chk = 1'b0; slave_en = 1'b0;
    check("t2_mosi_seq", 32'(mosi_seq), 32'h3C);
    check("t2_mosi_on_fall", 32'(mosi_bad - base), 32'h0);
    check("t2_sclk_end", 32'(sclk), 32'h1);

    // Three-word burst on slave 2
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_ss_sel = 2'd2;
    repeat (2) @(negedge clk);
    base = rx_count; bad = ss_bad; ss_exp = 4'b1011;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    send_word(8'h11, 1'b0, t);
    ss_watch = 1'b1;
    send_word(8'h22, 1'b0, t);
    send_word(8'h33, 1'b1, t);
    wait_rx(base + 3);
    ss_watch = 1'b0;
    check("t3_ss_continuous", 32'(ss_bad - bad), 32'h0);
    wait_idle(ti);
    check("t3_rx_pulses", 32'(rx_count - base), 32'd3);
    check("t3_ss_released", 32'(ss_n), 32'hF);

    // Backpressure with cfg_ss_sel toggling while the source waits
    cfg_ss_sel = 2'd1;
    @(negedge clk);
    bad = ss_bad; ss_exp = 4'b1101;
    exp_q.push_back(8'h66); exp_q.push_back(8'h99);
    send_word(8'h66, 1'b0, t);
    ss_watch = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h99; tx_last = 1'b1; n = 0;
    while (tx_ready !== 1'b1 && n < 500) begin
      cfg_ss_sel = (cfg_ss_sel == 2'd1) ? 2'd3 : 2'd1;
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t4_accept_in_wait", 32'(t2), 32'(t + 66));
    check("t4_busy_second", 32'(busy), 32'h1);
    base = rx_count;
    wait_rx(base + 1);
    ss_watch = 1'b0;
    check("t4_orig_slave", 32'(ss_bad - bad), 32'h0);
    wait_idle(ti);

    // Mode 1: reset on edge 7, then a fresh transfer
    cfg_cpol = 1'b0; cfg_cpha = 1'b1; cfg_ss_sel = 2'd0;
    repeat (2) @(negedge clk);
    edge_q.delete();
    send_word(8'hC3, 1'b1, t);
    n = 0;
    while (edge_q.size() < 7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_edge7_timeout", 32'(n < 200), 32'h1);
    rst = 1'b1;
    #1;
    check("t5_rst_sclk", 32'(sclk), 32'h0);
    check("t5_rst_mosi", 32'(mosi), 32'h0);
    check("t5_rst_ss_n", 32'(ss_n), 32'hF);
    check("t5_rst_tx_ready", 32'(tx_ready), 32'h0);
    check("t5_rst_rx_valid", 32'(rx_valid), 32'h0);
    check("t5_rst_rx_data", 32'(rx_data), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after", 32'(tx_ready), 32'h1);
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 1'b1, t);
    wait_idle(ti);
    check("t5_rx_held", 32'(rx_data), 32'h5A);

    // Mode 2 stall in WAIT for 50 cycles
    cfg_cpol = 1'b1; cfg_cpha = 1'b0; cfg_ss_sel = 2'd3;
    repeat (2) @(negedge clk);
    base = rx_count;
    exp_q.push_back(8'h0F);
    send_word(8'h0F, 1'b0, t);
    wait_rx(base + 1);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (sclk !== 1'b1 || ss_n !== 4'b0111 || rx_valid !== 1'b0 || tx_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    check("t6_wait_static", 32'(bad), 32'h0);
    exp_q.push_back(8'hF0);
    send_word(8'hF0, 1'b1, t);
    wait_idle(ti);
    check("t6_rx_pulses", 32'(rx_count - base), 32'd2);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
